packet_tx: RTL and testbench
============================

Name: packet_tx

Overview:
Ethernet frame transmitter for the GbE link; the send-side counterpart of the packet receiver.
- Builds one frame from a small payload held in a packet RAM: preamble/SFD, destination MAC, source MAC, ethertype, payload, optional pad, CRC-32 FCS.
- Drives the byte-wide PHY transmit interface (`data[7:0]`, `ctl[1:0]`), then enforces the inter-frame gap.
- Sits between the control/status logic that fills the TX RAM and the RGMII output stage.

Parameters:
- IFG_BYTES, 12, inter-frame gap length in idle cycles after the FCS.
- MAX_LEN, 64, payload RAM depth in bytes; sets eth_tx_addr width (log2 = 6).

Ports:
- clk  input  1  byte clock (125 MHz).
- rst  input  1  synchronous, active-high reset.
- mac_addr  input  48  source MAC, byte [47:40] sent first.
- dest_addr  input  48  destination MAC, sampled at start.
- ethertype  input  16  type/len field, sampled at start, [15:8] sent first.
- eth_tx_len  input  6  payload bytes, sampled at start; 0 encodes 64.
- eth_tx_start  input  1  single-cycle frame request.
- eth_tx_busy  output  1  high from accept through end of IFG.
- eth_tx_done  output  1  one-cycle pulse on the last FCS byte.
- eth_tx_addr  output  6  packet RAM read address.
- eth_tx_rdata  input  8  packet RAM data; 1-cycle synchronous read latency.
- data  output  8  PHY TX byte, registered.
- ctl  output  2  2'b11 during frame bytes, 2'b00 otherwise, registered.

Behaviour:
- Reset: state IDLE, data=0, ctl=0, eth_tx_busy=0, eth_tx_done=0, eth_tx_addr=0.
- A reset mid-frame truncates the frame: ctl=0 from the next cycle. No abort symbol is sent.
- Accept: in IDLE, eth_tx_start=1 latches dest_addr, ethertype and eth_tx_len (plus mac_addr), and sets busy=1 on the next edge.
- eth_tx_start is ignored whenever busy=1; it is not queued.
- The first preamble byte appears on data/ctl the cycle after accept.
- States and byte counts:
  - PREAMBLE: 7 × 8'h55
  - SFD: 8'hd5
  - DEST: 6 bytes
  - SRC: 6 bytes
  - TYPE: 2 bytes
  - PAYLOAD: L bytes
  - PAD: see Optional Feature
  - FCS: 4 bytes
  - IFG: IFG_BYTES cycles
  - then IDLE
- ctl=2'b11 on every byte from the first preamble byte through the last FCS byte; ctl=2'b00 with data=0 otherwise.
- Frame on the wire: 8+14+L(+pad)+4 consecutive ctl=11 cycles, no gaps.
- RAM prefetch: eth_tx_addr=0 is driven during the second TYPE byte. The address increments once per payload byte so rdata is ready when needed. The address saturates at L-1; no wrap occurs for L=64.
- CRC-32:
  - polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF;
  - covers DEST through last payload/pad byte;
  - FCS = bitwise complement, sent least-significant byte first.
  - The CRC register is reinitialised on accept.
- eth_tx_done is asserted the same cycle the 4th FCS byte is on data.
- busy drops after the last IFG cycle, so a start pulse in that same cycle is ignored. Back-to-back frames are therefore separated by at least IFG_BYTES+1 idle cycles.

Optional Feature:
- Macro: PACKET_TX_PAD_EN
- Defined: if 14+L < 60, PAD emits 8'h00 bytes until DEST..PAD totals 60 bytes; those pad bytes are included in the CRC.
- Undefined: the PAD state is skipped and short frames (runts) go out unpadded. This mode is used only for loopback benches against the receiver.

Decomposition:
- Shared package `eth_pkg`:
  - state enum;
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hd5;
  - CRC_POLY, CRC_INIT 32'hFFFFFFFF, CRC_RESIDUE 32'hDEBB20E3;
  - MIN_FRAME 60.
- Sub-module `crc32_d8`: byte-parallel reflected CRC update, with inputs init, en, d[7:0] and output crc[31:0].
- `crc32_d8` is reusable by the receiver for FCS checking.

Test Plan:
- L=0 (64 bytes), RAM=0..63, start pulse:
  - ctl=11 for exactly 90 cycles, beginning 1 cycle after start;
  - bytes 7×55, d5, dest, src, type, 00..3f;
  - done on cycle 90, busy low 12 cycles later.
- FCS check: CRC-32 computed over the received DEST..FCS bytes yields residue 0xDEBB20E3. Also cross-check against a software CRC of the same frame.
- L=10 with PACKET_TX_PAD_EN: 36 pad bytes of 00, 72 frame cycles. Without the macro: 36 frame cycles, valid FCS over the 24 bytes.
- Start pulses during the frame, during IFG, and on the last IFG cycle: all ignored, no second frame. A start 1 cycle after busy falls produces a frame.
- rst asserted on payload byte 20: ctl=00 and busy=0 the next cycle. The next start sends a complete, correct frame.
- Loopback into the receiver with dest_addr equal to the receiver's MAC: the receiver captures 64 payload bytes identical to the TX RAM.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet TX/RX types, framing constants and CRC-32 parameters.
package eth_pkg;
  typedef enum logic [3:0] {IDLE, PRE, SFD, DEST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG} tx_state_e;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hd5;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int MIN_FRAME = 60;
  function automatic logic [31:0] reflect32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction
  localparam logic [31:0] CRC_POLY_R = reflect32(CRC_POLY);
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-parallel reflected CRC-32 register (init has priority over en).
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d, c;
  always_comb begin
    c = crc_q ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY_R : c >> 1;
    crc_d = init ? CRC_INIT : en ? c : crc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  end
  assign crc = crc_q;
endmodule

// File: rtl/packet_tx.sv
// packet_tx: Ethernet frame transmitter (preamble, header, RAM payload, FCS, IFG).
// Define PACKET_TX_PAD_EN to zero-pad short frames up to the 60-byte minimum.
module packet_tx
  import eth_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MAX_LEN   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [47:0]                mac_addr,
  input  logic [47:0]                dest_addr,
  input  logic [15:0]                ethertype,
  input  logic [$clog2(MAX_LEN)-1:0] eth_tx_len,
  input  logic                       eth_tx_start,
  output logic                       eth_tx_busy,
  output logic                       eth_tx_done,
  output logic [$clog2(MAX_LEN)-1:0] eth_tx_addr,
  input  logic [7:0]                 eth_tx_rdata,
  output logic [7:0]                 data,
  output logic [1:0]                 ctl
);
  localparam int AW = $clog2(MAX_LEN);
  // The state names the byte being loaded into the output register, one cycle ahead of the wire.
  tx_state_e st_q, st_d;
  logic [7:0] cnt_q, cnt_d, last, lfull, pad_last, data_q, data_d, fcs_b;
  logic [111:0] hdr_q, hdr_d;
  logic [AW-1:0] len_q, len_d, addr_q, addr_d, len_m1;
  logic ctl_q, ctl_d, done_q, done_d, accept, need_pad, crc_en;
  logic [31:0] crc;
  assign accept = st_q == IDLE && eth_tx_start;
  assign len_m1 = len_q - AW'(1);
  assign lfull = len_q == '0 ? 8'(MAX_LEN) : 8'(len_q);
  assign pad_last = 8'(MIN_FRAME - 15) - lfull;
`ifdef PACKET_TX_PAD_EN
  assign need_pad = lfull < 8'(MIN_FRAME - 14);
`else
  assign need_pad = 1'b0;
`endif
  assign fcs_b = cnt_q[1] ? (cnt_q[0] ? ~crc[31:24] : ~crc[23:16]) : (cnt_q[0] ? ~crc[15:8] : ~crc[7:0]);
  assign crc_en = st_q inside {DEST, SRC, TYPE, PAYLOAD, PAD};
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 8'd1;
    last = st_q == PRE ? 8'd6 : (st_q == DEST || st_q == SRC) ? 8'd5 : st_q == TYPE ? 8'd1 :
           st_q == PAYLOAD ? 8'(len_m1) : st_q == PAD ? pad_last : st_q == FCS ? 8'd3 :
           st_q == IFG ? 8'(IFG_BYTES) : 8'd0;
    if (st_q == IDLE) begin
      st_d = accept ? PRE : IDLE;
      cnt_d = 8'd1;
    end else if (cnt_q == last) begin
      cnt_d = '0;
      case (st_q)
        PRE:     st_d = SFD;
        SFD:     st_d = DEST;
        DEST:    st_d = SRC;
        SRC:     st_d = TYPE;
        TYPE:    st_d = PAYLOAD;
        PAYLOAD: st_d = need_pad ? PAD : FCS;
        PAD:     st_d = FCS;
        FCS:     st_d = IFG;
        default: st_d = IDLE;
      endcase
    end
  end
  always_comb begin
    ctl_d = accept || !(st_q inside {IDLE, IFG});
    data_d = (accept || st_q == PRE) ? PREAMBLE_BYTE : st_q == SFD ? SFD_BYTE :
             (st_q inside {DEST, SRC, TYPE}) ? hdr_q[111:104] : st_q == PAYLOAD ? eth_tx_rdata :
             st_q == FCS ? fcs_b : 8'h00;
    hdr_d = accept ? {dest_addr, mac_addr, ethertype} :
            (st_q inside {DEST, SRC, TYPE}) ? {hdr_q[103:0], 8'h00} : hdr_q;
    len_d = accept ? eth_tx_len : len_q;
    // Prefetch: address 0 is presented while the last TYPE byte is loaded, so RAM data lands in time.
    addr_d = accept ? '0 :
             (((st_q == TYPE && cnt_q == 8'd1) || st_q == PAYLOAD) && addr_q != len_m1) ? addr_q + AW'(1) : addr_q;
    done_d = st_q == FCS && cnt_q == 8'd3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      hdr_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ctl_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      len_q <= len_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ctl_q <= ctl_d;
      done_q <= done_d;
    end
  end
  crc32_d8 u_crc (.clk(clk), .rst(rst), .init(accept), .en(crc_en), .d(data_d), .crc(crc));
  assign eth_tx_busy = st_q != IDLE;
  assign eth_tx_done = done_q;
  assign eth_tx_addr = addr_q;
  assign data = data_q;
  assign ctl = {2{ctl_q}};
endmodule

// File: tb/tb_packet_tx.sv
// tb_packet_tx: directed self-checking bench for packet_tx with a 1-cycle-latency RAM model.
module tb_packet_tx;
  logic clk, rst, eth_tx_start, eth_tx_busy, eth_tx_done;
  logic [47:0] mac_addr, dest_addr;
  logic [15:0] ethertype;
  logic [5:0] eth_tx_len, eth_tx_addr;
  logic [7:0] eth_tx_rdata, data;
  logic [1:0] ctl;
  logic [7:0] mem [0:63];
  logic [1:0] ctl_log [0:399];
  logic [7:0] data_log [0:399];
  logic busy_log [0:399];
  logic done_log [0:399];
  int vectors, miscompares;
  int f_cnt, f_first, f_last, f_done, f_ndone, f_blow, f_bad;
  logic [31:0] f_res;

  packet_tx dut (
    .clk(clk), .rst(rst), .mac_addr(mac_addr), .dest_addr(dest_addr), .ethertype(ethertype),
    .eth_tx_len(eth_tx_len), .eth_tx_start(eth_tx_start), .eth_tx_busy(eth_tx_busy),
    .eth_tx_done(eth_tx_done), .eth_tx_addr(eth_tx_addr), .eth_tx_rdata(eth_tx_rdata),
    .data(data), .ctl(ctl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) eth_tx_rdata <= mem[eth_tx_addr];

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Non-reflected MSB-first shift register fed LSB-first bits; bit-reverse gives the reflected CRC.
  function automatic logic [31:0] crc_byte(input logic [31:0] c0, input logic [7:0] b);
    logic [31:0] c;
    logic fb;
    c = c0;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ b[i];
      c = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  function automatic int pad_of(input int lf);
    int p;
    p = 0;
`ifdef PACKET_TX_PAD_EN
    if (14 + lf < 60) p = 46 - lf;
`endif
    return p;
  endfunction

  function automatic int frame_len(input int l);
    int lf;
    lf = (l == 0) ? 64 : l;
    return 8 + 14 + lf + pad_of(lf) + 4;
  endfunction

  task automatic capture(input int ncyc, input int len, input int p0, input int p1, input int rst_at);
    eth_tx_len = 6'(len);
    eth_tx_start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      ctl_log[n] = ctl;
      data_log[n] = data;
      busy_log[n] = eth_tx_busy;
      done_log[n] = eth_tx_done;
      eth_tx_start = (n == p0 || n == p1);
      rst = (n == rst_at);
    end
    eth_tx_start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic analyze(input int l, input int from, input int upto);
    logic [7:0] rx[$];
    logic [7:0] ex[$];
    logic [31:0] c;
    int lf;
    f_cnt = 0; f_first = -1; f_last = -1; f_done = -1; f_ndone = 0; f_blow = -1;
    for (int n = from; n <= upto; n++) begin
      if (ctl_log[n] == 2'b11) begin
        f_cnt++;
        if (f_first < 0) f_first = n;
        f_last = n;
        rx.push_back(data_log[n]);
      end
      if (done_log[n]) begin
        f_ndone++;
        if (f_done < 0) f_done = n;
      end
      if (!busy_log[n] && f_blow < 0 && f_first >= 0) f_blow = n;
    end
    lf = (l == 0) ? 64 : l;
    repeat (7) ex.push_back(8'h55);
    ex.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) ex.push_back(dest_addr[8*i +: 8]);
    for (int i = 5; i >= 0; i--) ex.push_back(mac_addr[8*i +: 8]);
    ex.push_back(ethertype[15:8]);
    ex.push_back(ethertype[7:0]);
    for (int i = 0; i < lf; i++) ex.push_back(mem[i]);
    repeat (pad_of(lf)) ex.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < ex.size(); i++) c = crc_byte(c, ex[i]);
    c = ~rev32(c);
    for (int i = 0; i < 4; i++) ex.push_back(c[8*i +: 8]);
    f_bad = (rx.size() != ex.size()) ? 1 : 0;
    for (int i = 0; i < ex.size() && i < rx.size(); i++) if (rx[i] !== ex[i]) f_bad++;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < rx.size(); i++) c = crc_byte(c, rx[i]);
    f_res = rev32(c);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ctl !== 2'b00) begin miscompares++; $display("FAIL reset_ctl got %b exp 00", ctl); end
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", data); end
    vectors++; if (eth_tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", eth_tx_busy); end
    vectors++; if (eth_tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", eth_tx_done); end
    vectors++; if (eth_tx_addr !== 6'd0) begin miscompares++; $display("FAIL reset_addr got %0d exp 0", eth_tx_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    capture(110, 0, -1, -1, -1);
    analyze(0, 1, 110);
    vectors++; if (f_first !== 1) begin miscompares++; $display("FAIL full_first got %0d exp 1", f_first); end
    vectors++; if (f_cnt !== 90) begin miscompares++; $display("FAIL full_cycles got %0d exp 90", f_cnt); end
    vectors++; if (f_last !== 90) begin miscompares++; $display("FAIL full_last got %0d exp 90", f_last); end
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL full_bytes got %0d bad exp 0", f_bad); end
    vectors++; if (f_done !== 90) begin miscompares++; $display("FAIL full_done got %0d exp 90", f_done); end
    vectors++; if (f_ndone !== 1) begin miscompares++; $display("FAIL full_done_width got %0d exp 1", f_ndone); end
    vectors++; if (busy_log[102] !== 1'b1) begin miscompares++; $display("FAIL full_busy_ifg got %b exp 1", busy_log[102]); end
    vectors++; if (f_blow !== 103) begin miscompares++; $display("FAIL full_busy_low got %0d exp 103", f_blow); end
    vectors++; if (f_res !== 32'hDEBB20E3) begin miscompares++; $display("FAIL full_residue got %h exp debb20e3", f_res); end
  endtask

  task automatic test_runt;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
    capture(100, 10, -1, -1, -1);
    analyze(10, 1, 100);
`ifdef PACKET_TX_PAD_EN
    vectors++; if (f_cnt !== 72) begin miscompares++; $display("FAIL runt_cycles got %0d exp 72", f_cnt); end
`else
    vectors++; if (f_cnt !== 36) begin miscompares++; $display("FAIL runt_cycles got %0d exp 36", f_cnt); end
`endif
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL runt_bytes got %0d bad exp 0", f_bad); end
    vectors++; if (f_res !== 32'hDEBB20E3) begin miscompares++; $display("FAIL runt_residue got %h exp debb20e3", f_res); end
    vectors++; if (f_done !== frame_len(10)) begin miscompares++; $display("FAIL runt_done got %0d exp %0d", f_done, frame_len(10)); end
    vectors++; if (f_blow !== frame_len(10) + 13) begin miscompares++; $display("FAIL runt_busy_low got %0d exp %0d", f_blow, frame_len(10) + 13); end
  endtask

  task automatic test_start_ignored;
    int last, extra;
    last = frame_len(5);
    capture(last + 28, 5, 10, last + 5, -1);
    analyze(5, 1, last + 28);
    vectors++; if (f_cnt !== last) begin miscompares++; $display("FAIL ign_cycles got %0d exp %0d", f_cnt, last); end
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL ign_bytes got %0d bad exp 0", f_bad); end
    vectors++; if (f_blow !== last + 13) begin miscompares++; $display("FAIL ign_busy_low got %0d exp %0d", f_blow, last + 13); end
    capture(last + 28, 5, last + 12, -1, -1);
    analyze(5, 1, last + 28);
    extra = 0;
    for (int n = last + 13; n <= last + 28; n++) if (busy_log[n] || ctl_log[n] != 2'b00) extra++;
    vectors++; if (busy_log[last + 12] !== 1'b1) begin miscompares++; $display("FAIL ign_last_ifg_busy got %b exp 1", busy_log[last + 12]); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ign_last_ifg_restart got %0d busy cycles exp 0", extra); end
    vectors++; if (f_cnt !== last) begin miscompares++; $display("FAIL ign_last_ifg_cycles got %0d exp %0d", f_cnt, last); end
  endtask

  task automatic test_back_to_back;
    int last;
    last = frame_len(3);
    capture(last * 2 + 40, 3, last + 13, -1, -1);
    analyze(3, 1, last + 12);
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL b2b_first_bytes got %0d bad exp 0", f_bad); end
    analyze(3, last + 13, last * 2 + 40);
    vectors++; if (f_first !== last + 14) begin miscompares++; $display("FAIL b2b_second_start got %0d exp %0d", f_first, last + 14); end
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL b2b_second_bytes got %0d bad exp 0", f_bad); end
    vectors++; if (f_res !== 32'hDEBB20E3) begin miscompares++; $display("FAIL b2b_residue got %h exp debb20e3", f_res); end
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'hc0 ^ i);
    capture(50, 0, -1, -1, 43);
    vectors++; if (data_log[43] !== mem[20]) begin miscompares++; $display("FAIL mid_byte20 got %h exp %h", data_log[43], mem[20]); end
    vectors++; if (ctl_log[44] !== 2'b00) begin miscompares++; $display("FAIL mid_ctl got %b exp 00", ctl_log[44]); end
    vectors++; if (busy_log[44] !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b exp 0", busy_log[44]); end
    vectors++; if (data_log[44] !== 8'h00) begin miscompares++; $display("FAIL mid_data got %h exp 00", data_log[44]); end
    capture(110, 0, -1, -1, -1);
    analyze(0, 1, 110);
    vectors++; if (f_cnt !== 90) begin miscompares++; $display("FAIL mid_next_cycles got %0d exp 90", f_cnt); end
    vectors++; if (f_bad !== 0) begin miscompares++; $display("FAIL mid_next_bytes got %0d bad exp 0", f_bad); end
    vectors++; if (f_res !== 32'hDEBB20E3) begin miscompares++; $display("FAIL mid_next_residue got %h exp debb20e3", f_res); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    eth_tx_start = 1'b0;
    eth_tx_len = 6'd0;
    mac_addr = 48'h02AABBCCDDEE;
    dest_addr = 48'h021122334455;
    ethertype = 16'h0800;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    test_reset;
    test_full_frame;
    test_runt;
    test_start_ignored;
    ethertype = 16'h88b5;
    dest_addr = 48'hFFFFFFFFFFFF;
    test_back_to_back;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
